vga_line_capture: RTL and testbench

Camera-side writer for the binarized line memories that the VGA output stage reads. It takes the camera pixel stream with VSYNC/HSYNC/DE timing and thresholds each pixel to 1 bit. It packs each active line into an HACTIVE-bit word and writes that word, one word per line, into the line memory at address = line number. It sits between the camera input and the dual-port line SRAM and produces the MEMOUT_0 data plane.

---
 rtl/vga_capture_pkg.sv | 17 +
 rtl/vga_line_capture_line_packer.sv | 58 +++++
 rtl/vga_line_capture.sv | 135 +++++++++++++
 tb/tb_vga_line_capture.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_capture_pkg.sv
// Shared types and helpers for the camera-side binarized line capture (vga_line_capture).
package vga_capture_pkg;

   typedef enum logic [1:0] {IDLE, FRAME, LINE, WRITE} state_t;

   localparam int HACTIVE_DEF = 640;
   localparam int VACTIVE_DEF = 480;
   localparam int PIX_W_MAX   = 32;

   // Pixels arrive zero-extended to PIX_W_MAX so one compare serves any camera width.
   function automatic logic binarize(input logic [PIX_W_MAX-1:0] pixel,
                                     input logic [PIX_W_MAX-1:0] threshold,
                                     input logic                 dark_is_one);
      return dark_is_one ? (pixel < threshold) : (pixel >= threshold);
   endfunction

endpackage

// File: rtl/vga_line_capture_line_packer.sv
// Packs binarized pixels of one line into an HACTIVE-bit word and checks the line length.
// Optional horizontal 3-tap majority filter: `define VGA_LINE_CAPTURE_HFILTER_EN.
module vga_line_capture_line_packer #(
   parameter int HACTIVE = 640
) (
   input  logic               VCLK,
   input  logic               RST_N,
   input  logic               start,
   input  logic               capture,
   input  logic               bit_in,
   output logic [HACTIVE-1:0] data,
   output logic               length_ok
);

   localparam int HW = $clog2(HACTIVE + 2);
   localparam int IW = $clog2(HACTIVE);

   logic [HW-1:0]      h_cnt;
   logic [HACTIVE-1:0] raw;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of block ordering.
   // NOTE: the line register is reset along with the counter so an aborted
   // line can never leak stale bits into a later short line.
   always_ff @(posedge VCLK or negedge RST_N) begin
      if (!RST_N) begin
         h_cnt <= '0;
         raw   <= '0;
      end else if (start) begin
         raw   <= HACTIVE'(bit_in);
         h_cnt <= HW'(1);
      end else if (capture) begin
         if (h_cnt < HW'(HACTIVE))
            raw[h_cnt[IW-1:0]] <= bit_in;
         // Saturating one past HACTIVE is enough to tell "too long" from "exact".
         if (h_cnt != HW'(HACTIVE + 1))
            h_cnt <= h_cnt + 1'b1;
      end
   end

   assign length_ok = (h_cnt == HW'(HACTIVE));

`ifdef VGA_LINE_CAPTURE_HFILTER_EN
   logic [HACTIVE+1:0] padded;
   assign padded = {1'b0, raw, 1'b0};

   // Majority over the fully captured raw line, so the last bit is ready at the DE fall.
   always_comb begin
      data = '0;
      for (int n = 0; n < HACTIVE; n++)
         data[n] = (padded[n] & padded[n+1]) | (padded[n] & padded[n+2]) |
                   (padded[n+1] & padded[n+2]);
   end
`else
   assign data = raw;
`endif

endmodule

// File: rtl/vga_line_capture.sv
// Camera-side writer of binarized lines into the VGA line memory (MEMOUT_0 plane).
// Optional horizontal majority filter: `define VGA_LINE_CAPTURE_HFILTER_EN.
module vga_line_capture
   import vga_capture_pkg::*;
#(
   parameter int ADDR_WIDTH  = 11,
   parameter int HACTIVE     = HACTIVE_DEF,
   parameter int VACTIVE     = VACTIVE_DEF,
   parameter int PIXEL_WIDTH = 8,
   parameter int DARK_IS_ONE = 1
) (
   input  logic                   VCLK,
   input  logic                   RST_N,
   input  logic                   iCAPTURE_EN,
   input  logic                   iVSYNC,
   input  logic                   iHSYNC,
   input  logic                   iDE,
   input  logic [PIXEL_WIDTH-1:0] iPIXEL,
   input  logic [PIXEL_WIDTH-1:0] iTHRESHOLD,
   output logic                   oMEM_WE,
   output logic [ADDR_WIDTH-1:0]  oMEM_ADDR,
   output logic [HACTIVE-1:0]     oMEM_DATA,
   output logic                   oFRAME_DONE,
   output logic [ADDR_WIDTH-1:0]  oLINE_CNT,
   output logic                   oLINE_ERR
);

   localparam logic [ADDR_WIDTH-1:0] V_LIMIT = ADDR_WIDTH'(VACTIVE);

   state_t                 state, state_next;
   logic                   vsync_q, de_q, vsync_rise, de_rise, pix_bit;
   logic                   start_line, capture, line_end, frame_end, abort_line, new_frame;
   logic [HACTIVE-1:0]     line_data;
   logic                   length_ok;
   logic [ADDR_WIDTH-1:0]  v_cnt;
   logic                   unused_hsync;

   assign unused_hsync = iHSYNC;
   assign vsync_rise   = iVSYNC & ~vsync_q;
   assign de_rise      = iDE & ~de_q;
   assign pix_bit      = binarize(PIX_W_MAX'(iPIXEL), PIX_W_MAX'(iTHRESHOLD), DARK_IS_ONE != 0);

   vga_line_capture_line_packer #(.HACTIVE(HACTIVE)) u_packer (
      .VCLK      (VCLK),
      .RST_N     (RST_N),
      .start     (start_line),
      .capture   (capture),
      .bit_in    (pix_bit),
      .data      (line_data),
      .length_ok (length_ok)
   );

   always_ff @(posedge VCLK or negedge RST_N) begin
      if (!RST_N) state <= IDLE;
      else        state <= state_next;
   end

   // NOTE: every signal driven here gets a default first; a path that skips an
   // assignment would otherwise infer a latch.
   always_comb begin
      state_next = state;
      start_line = 1'b0;
      capture    = 1'b0;
      line_end   = 1'b0;
      frame_end  = 1'b0;
      abort_line = 1'b0;
      new_frame  = 1'b0;
      case (state)
         IDLE:  if (vsync_rise && iCAPTURE_EN) begin
                   new_frame  = 1'b1;
                   state_next = FRAME;
                end
         FRAME: if (vsync_rise) frame_end = 1'b1;
                else if (de_rise) begin
                   start_line = 1'b1;
                   state_next = LINE;
                end
         LINE:  if (vsync_rise) begin
                   abort_line = 1'b1;
                   frame_end  = 1'b1;
                end else if (iDE) capture = 1'b1;
                else begin
                   line_end   = 1'b1;
                   state_next = WRITE;
                end
         WRITE: if (vsync_rise) frame_end = 1'b1;
                else state_next = FRAME;
         default: state_next = IDLE;
      endcase
      // Capture enable is only honoured at frame boundaries.
      if (frame_end) begin
         new_frame  = iCAPTURE_EN;
         state_next = iCAPTURE_EN ? FRAME : IDLE;
      end
   end

   always_ff @(posedge VCLK or negedge RST_N) begin
      if (!RST_N) begin
         vsync_q     <= 1'b0;
         de_q        <= 1'b0;
         v_cnt       <= '0;
         oMEM_WE     <= 1'b0;
         oMEM_ADDR   <= '0;
         oMEM_DATA   <= '0;
         oFRAME_DONE <= 1'b0;
         oLINE_CNT   <= '0;
         oLINE_ERR   <= 1'b0;
      end else begin
         vsync_q     <= iVSYNC;
         de_q        <= iDE;
         oMEM_WE     <= 1'b0;
         oFRAME_DONE <= 1'b0;
         if (line_end) begin
            if (v_cnt < V_LIMIT) begin
               oMEM_WE   <= 1'b1;
               oMEM_ADDR <= v_cnt;
               oMEM_DATA <= line_data;
               v_cnt     <= v_cnt + 1'b1;
            end
            if (!length_ok) oLINE_ERR <= 1'b1;
         end
         if (frame_end) begin
            oFRAME_DONE <= 1'b1;
            oLINE_CNT   <= v_cnt;
         end
         if (abort_line) oLINE_ERR <= 1'b1;
         // Placed last so a continuing capture wins over the abort flag.
         if (new_frame) begin
            v_cnt     <= '0;
            oLINE_ERR <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_vga_line_capture.sv
// Self-checking bench for vga_line_capture: randomized lines against a line-level reference model.
module tb_vga_line_capture;

   localparam int HACT = 640;
   localparam int VACT = 480;
   localparam int AW   = 11;
   localparam int PW   = 8;

   logic            VCLK = 1'b0;
   logic            RST_N;
   logic            iCAPTURE_EN, iVSYNC, iHSYNC, iDE;
   logic [PW-1:0]   iPIXEL, iTHRESHOLD;
   logic            oMEM_WE, oFRAME_DONE, oLINE_ERR;
   logic [AW-1:0]   oMEM_ADDR, oLINE_CNT;
   logic [HACT-1:0] oMEM_DATA;

   vga_line_capture #(.ADDR_WIDTH(AW), .HACTIVE(HACT), .VACTIVE(VACT),
                      .PIXEL_WIDTH(PW), .DARK_IS_ONE(1)) dut (
      .VCLK(VCLK), .RST_N(RST_N), .iCAPTURE_EN(iCAPTURE_EN), .iVSYNC(iVSYNC),
      .iHSYNC(iHSYNC), .iDE(iDE), .iPIXEL(iPIXEL), .iTHRESHOLD(iTHRESHOLD),
      .oMEM_WE(oMEM_WE), .oMEM_ADDR(oMEM_ADDR), .oMEM_DATA(oMEM_DATA),
      .oFRAME_DONE(oFRAME_DONE), .oLINE_CNT(oLINE_CNT), .oLINE_ERR(oLINE_ERR));

   always #5 VCLK = ~VCLK;

   int cyc = 0;
   always @(posedge VCLK) cyc <= cyc + 1;

   typedef struct {
      logic [AW-1:0]   addr;
      logic [HACT-1:0] data;
      int              cyc;
   } wr_t;

   wr_t got_q[$], exp_q[$];
   int  done_q[$], exp_done_q[$], lp_q[$];
   int  n_checks = 0, n_fail = 0;

   // Reference model state: frame active, lines written, sticky error.
   bit m_active;
   int m_v;
   bit m_err;

   always @(negedge VCLK) begin
      wr_t w;
      if (RST_N === 1'b1 && oMEM_WE === 1'b1) begin
         w.addr = oMEM_ADDR; w.data = oMEM_DATA; w.cyc = cyc;
         got_q.push_back(w);
      end
      if (RST_N === 1'b1 && oFRAME_DONE === 1'b1) done_q.push_back(int'(oLINE_CNT));
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish, got time %0t, required < 2ms", $time);
      $fatal(1);
   end

   // Expected stored word from the per-pixel dark flags and the received line length.
   function automatic logic [HACT-1:0] model_word(input int len, input logic [1023:0] dark);
      logic [HACT-1:0] raw, w;
      int s;
      for (int i = 0; i < HACT; i++) raw[i] = (i < len) ? dark[i] : 1'b0;
`ifdef VGA_LINE_CAPTURE_HFILTER_EN
      for (int i = 0; i < HACT; i++) begin
         s = int'(raw[i]);
         if (i > 0)        s += int'(raw[i-1]);
         if (i < HACT - 1) s += int'(raw[i+1]);
         w[i] = (s >= 2);
      end
`else
      w = raw;
`endif
      return w;
   endfunction

   function automatic logic [1023:0] rand_mask();
      logic [1023:0] m;
      for (int k = 0; k < 32; k++) m[k*32 +: 32] = $urandom;
      return m;
   endfunction

   function automatic logic [PW-1:0] pix_for(input bit dark, input int thr);
      return dark ? PW'($urandom_range(thr - 1, 0)) : PW'($urandom_range(255, thr));
   endfunction

   task automatic tick();
      @(negedge VCLK);
   endtask

   task automatic reset_queues();
      got_q.delete(); exp_q.delete(); done_q.delete(); exp_done_q.delete(); lp_q.delete();
   endtask

   task automatic vsync_pulse(input bit en);
      iCAPTURE_EN = en;
      if (m_active) begin
         exp_done_q.push_back(m_v);
         if (en) begin m_v = 0; m_err = 0; end
         m_active = en;
      end else if (en) begin
         m_active = 1; m_v = 0; m_err = 0;
      end
      iVSYNC = 1'b1;
      repeat (3) tick();
      iVSYNC = 1'b0;
      repeat (3) tick();
   endtask

   task automatic send_line(input int len, input logic [1023:0] dark, input int thr, input int blank);
      wr_t w;
      iTHRESHOLD = PW'(thr);
      if (m_active) begin
         if (len != HACT) m_err = 1;
         if (m_v < VACT) begin
            w.addr = AW'(m_v); w.data = model_word(len, dark); w.cyc = 0;
            exp_q.push_back(w);
            m_v++;
         end
      end
      for (int i = 0; i < len; i++) begin
         iDE    = 1'b1;
         iPIXEL = pix_for(dark[i], thr);
         if (i == len - 1) lp_q.push_back(cyc);
         tick();
      end
      iDE    = 1'b0;
      iPIXEL = '0;
      repeat (blank) tick();
   endtask

   task automatic test_reset();
      RST_N = 1'b0;
      repeat (3) tick();
      n_checks += 6;
      if (oMEM_WE !== 1'b0)     begin n_fail++; $display("FAIL reset_we: got %b, expected 0", oMEM_WE); end
      if (oMEM_ADDR !== '0)     begin n_fail++; $display("FAIL reset_addr: got %0d, expected 0", oMEM_ADDR); end
      if (oMEM_DATA !== '0)     begin n_fail++; $display("FAIL reset_data: got nonzero %h, expected 0", oMEM_DATA); end
      if (oFRAME_DONE !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b, expected 0", oFRAME_DONE); end
      if (oLINE_CNT !== '0)     begin n_fail++; $display("FAIL reset_line_cnt: got %0d, expected 0", oLINE_CNT); end
      if (oLINE_ERR !== 1'b0)   begin n_fail++; $display("FAIL reset_err: got %b, expected 0", oLINE_ERR); end
      RST_N = 1'b1;
      repeat (2) tick();
      // Reset in the middle of a line: nothing may be written afterwards.
      vsync_pulse(1'b1);
      reset_queues();
      for (int i = 0; i < 100; i++) begin
         iDE = 1'b1; iPIXEL = pix_for(i[0], 128); tick();
      end
      #2 RST_N = 1'b0;
      #1;
      n_checks++;
      if (oLINE_ERR !== 1'b0 || oMEM_WE !== 1'b0)
         begin n_fail++; $display("FAIL midline_reset_outputs: got we=%b err=%b, expected 0 0", oMEM_WE, oLINE_ERR); end
      tick();
      iDE = 1'b0;
      repeat (4) tick();
      RST_N = 1'b1;
      m_active = 0; m_v = 0; m_err = 0;
      repeat (8) tick();
      n_checks++;
      if (got_q.size() != 0) begin n_fail++; $display("FAIL midline_reset_write: got %0d writes, expected 0", got_q.size()); end
   endtask

   task automatic test_basic();
      logic [1023:0] l1;
      vsync_pulse(1'b1);
      reset_queues();
      l1 = '0;
      for (int i = 100; i <= 109; i++) l1[i] = 1'b1;
      send_line(HACT, rand_mask(), 8'h80, 6);
      send_line(HACT, l1, 8'h80, 6);
      send_line(HACT, rand_mask(), 8'h80, 6);
      n_checks++;
      if (oLINE_ERR !== 1'b0) begin n_fail++; $display("FAIL basic_err: got %b, expected 0", oLINE_ERR); end
      vsync_pulse(1'b1);
      n_checks++;
      if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL basic_count: got %0d writes, expected %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         n_checks++;
         if (got_q[i].addr !== exp_q[i].addr || got_q[i].data !== exp_q[i].data) begin
            n_fail++;
            $display("FAIL basic_write[%0d]: got addr %0d data %h, expected addr %0d data %h", i, got_q[i].addr, got_q[i].data, exp_q[i].addr, exp_q[i].data);
         end
      end
      if (got_q.size() > 0 && lp_q.size() > 0) begin
         n_checks++;
         if (got_q[0].cyc - lp_q[0] != 2) begin n_fail++; $display("FAIL basic_latency: got %0d cycles, expected 2", got_q[0].cyc - lp_q[0]); end
      end
      n_checks++;
      if (done_q.size() != 1 || done_q[0] != 3) begin
         n_fail++; $display("FAIL basic_frame_done: got %0d pulses (first cnt %0d), expected 1 pulse cnt 3", done_q.size(), done_q.size() > 0 ? done_q[0] : -1);
      end
   endtask

   task automatic test_short_line();
      logic [1023:0] m;
      reset_queues();
      m = rand_mask();
      m[HACT-1] = 1'b1;
      send_line(HACT - 1, m, 8'h80, 6);
      n_checks++;
      if (oLINE_ERR !== 1'b1) begin n_fail++; $display("FAIL short_err_set: got %b, expected 1", oLINE_ERR); end
      send_line(HACT, rand_mask(), 8'h80, 6);
      n_checks++;
      if (got_q.size() != 2) begin n_fail++; $display("FAIL short_count: got %0d writes, expected 2", got_q.size()); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         n_checks++;
         if (got_q[i].addr !== exp_q[i].addr || got_q[i].data !== exp_q[i].data) begin
            n_fail++;
            $display("FAIL short_write[%0d]: got addr %0d data %h, expected addr %0d data %h", i, got_q[i].addr, got_q[i].data, exp_q[i].addr, exp_q[i].data);
         end
      end
      if (got_q.size() > 0) begin
         n_checks++;
         if (got_q[0].data[HACT-1] !== 1'b0) begin n_fail++; $display("FAIL short_bit639: got %b, expected 0", got_q[0].data[HACT-1]); end
      end
      vsync_pulse(1'b1);
      n_checks++;
      if (oLINE_ERR !== 1'b0) begin n_fail++; $display("FAIL short_err_clear: got %b, expected 0", oLINE_ERR); end
   endtask

   task automatic test_vactive_limit();
      int thr;
      reset_queues();
      thr = $urandom_range(255, 1);
      for (int l = 0; l < VACT + 2; l++) send_line(8, rand_mask(), thr, 3);
      n_checks++;
      if (got_q.size() != VACT) begin n_fail++; $display("FAIL vactive_count: got %0d writes, expected %0d", got_q.size(), VACT); end
      if (got_q.size() > 0) begin
         n_checks++;
         if (got_q[got_q.size()-1].addr !== AW'(VACT - 1))
            begin n_fail++; $display("FAIL vactive_last_addr: got %0d, expected %0d", got_q[got_q.size()-1].addr, VACT - 1); end
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         n_checks++;
         if (got_q[i].addr !== exp_q[i].addr || got_q[i].data !== exp_q[i].data) begin
            n_fail++;
            $display("FAIL vactive_write[%0d]: got addr %0d data %h, expected addr %0d data %h", i, got_q[i].addr, got_q[i].data, exp_q[i].addr, exp_q[i].data);
         end
      end
      vsync_pulse(1'b1);
      n_checks++;
      if (done_q.size() != 1 || done_q[0] != VACT)
         begin n_fail++; $display("FAIL vactive_line_cnt: got %0d pulses (first %0d), expected 1 pulse cnt %0d", done_q.size(), done_q.size() > 0 ? done_q[0] : -1, VACT); end
   endtask

   task automatic test_vsync_abort();
      reset_queues();
      send_line(HACT, rand_mask(), 8'h80, 6);
      for (int i = 0; i < 300; i++) begin
         iDE = 1'b1; iPIXEL = pix_for($urandom_range(1, 0) != 0, 128); tick();
      end
      exp_done_q.push_back(m_v);
      m_v = 0; m_err = 0;
      iVSYNC = 1'b1; iDE = 1'b1; tick();
      tick();
      iDE = 1'b0; tick();
      iVSYNC = 1'b0; repeat (3) tick();
      n_checks++;
      if (oLINE_ERR !== 1'b0) begin n_fail++; $display("FAIL abort_err_continue: got %b, expected 0", oLINE_ERR); end
      n_checks++;
      if (got_q.size() != 1) begin n_fail++; $display("FAIL abort_no_write: got %0d writes, expected 1", got_q.size()); end
      send_line(HACT, rand_mask(), 8'h80, 6);
      n_checks++;
      if (got_q.size() != 2 || got_q[got_q.size()-1].addr !== '0 || got_q[got_q.size()-1].data !== exp_q[exp_q.size()-1].data)
         begin n_fail++; $display("FAIL abort_restart: got %0d writes (last addr %0d), expected 2 writes last addr 0 matching data", got_q.size(), got_q.size() > 0 ? int'(got_q[got_q.size()-1].addr) : -1); end
      n_checks++;
      if (done_q.size() != 1 || done_q[0] != 1)
         begin n_fail++; $display("FAIL abort_done: got %0d pulses (first %0d), expected 1 pulse cnt 1", done_q.size(), done_q.size() > 0 ? done_q[0] : -1); end
      // Abort with capture stopping: error flag must survive.
      for (int i = 0; i < 100; i++) begin
         iDE = 1'b1; iPIXEL = 8'hF0; tick();
      end
      iCAPTURE_EN = 1'b0;
      exp_done_q.push_back(m_v);
      m_active = 0; m_err = 1;
      iVSYNC = 1'b1; tick(); tick();
      iDE = 1'b0; tick();
      iVSYNC = 1'b0; repeat (3) tick();
      n_checks++;
      if (oLINE_ERR !== 1'b1) begin n_fail++; $display("FAIL abort_err_stop: got %b, expected 1", oLINE_ERR); end
      n_checks++;
      if (done_q.size() != 2 || done_q[1] != 1)
         begin n_fail++; $display("FAIL abort_stop_done: got %0d pulses, expected 2 with second cnt 1", done_q.size()); end
   endtask

   task automatic test_capture_stop();
      vsync_pulse(1'b1);
      reset_queues();
      send_line(HACT, rand_mask(), 8'h60, 6);
      send_line(HACT, rand_mask(), 8'h60, 6);
      iCAPTURE_EN = 1'b0;
      send_line(HACT, rand_mask(), 8'h60, 6);
      send_line(HACT, rand_mask(), 8'h60, 6);
      vsync_pulse(1'b0);
      send_line(HACT, rand_mask(), 8'h60, 6);
      send_line(HACT, rand_mask(), 8'h60, 6);
      vsync_pulse(1'b0);
      n_checks++;
      if (got_q.size() != 4) begin n_fail++; $display("FAIL stop_count: got %0d writes, expected 4", got_q.size()); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         n_checks++;
         if (got_q[i].addr !== exp_q[i].addr || got_q[i].data !== exp_q[i].data) begin
            n_fail++;
            $display("FAIL stop_write[%0d]: got addr %0d data %h, expected addr %0d data %h", i, got_q[i].addr, got_q[i].data, exp_q[i].addr, exp_q[i].data);
         end
      end
      n_checks++;
      if (done_q.size() != exp_done_q.size() || done_q.size() != 1 || done_q[0] != 4)
         begin n_fail++; $display("FAIL stop_done: got %0d pulses (first %0d), expected 1 pulse cnt 4", done_q.size(), done_q.size() > 0 ? done_q[0] : -1); end
   endtask

   task automatic test_filter();
      logic [1023:0] m;
      vsync_pulse(1'b1);
      reset_queues();
      m = '0;
      m[50] = 1'b1;
      m[200] = 1'b1; m[201] = 1'b1; m[202] = 1'b1;
      send_line(HACT, m, 8'h80, 6);
      vsync_pulse(1'b1);
      n_checks++;
      if (got_q.size() != 1) begin n_fail++; $display("FAIL filter_count: got %0d writes, expected 1", got_q.size()); end
      if (got_q.size() > 0) begin
         n_checks++;
         if (got_q[0].data !== exp_q[0].data) begin n_fail++; $display("FAIL filter_word: got %h, expected %h", got_q[0].data, exp_q[0].data); end
         n_checks++;
`ifdef VGA_LINE_CAPTURE_HFILTER_EN
         if (got_q[0].data[50] !== 1'b0) begin n_fail++; $display("FAIL filter_bit50: got %b, expected 0", got_q[0].data[50]); end
`else
         if (got_q[0].data[50] !== 1'b1) begin n_fail++; $display("FAIL filter_bit50: got %b, expected 1", got_q[0].data[50]); end
`endif
         n_checks++;
         if (got_q[0].data[202:200] !== 3'b111) begin n_fail++; $display("FAIL filter_run: got %b, expected 111", got_q[0].data[202:200]); end
      end
   endtask

   task automatic test_random();
      int thr, len, r;
      reset_queues();
      for (int f = 0; f < 3; f++) begin
         thr = $urandom_range(255, 1);
         for (int l = 0; l < 3; l++) begin
            r   = $urandom_range(3, 0);
            len = (r == 0) ? HACT - 1 : (r == 1) ? HACT + 1 : HACT;
            send_line(len, rand_mask(), thr, $urandom_range(6, 3));
         end
         n_checks++;
         if (oLINE_ERR !== m_err) begin n_fail++; $display("FAIL random_err[%0d]: got %b, expected %b", f, oLINE_ERR, m_err); end
         vsync_pulse(1'b1);
      end
      n_checks++;
      if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL random_count: got %0d writes, expected %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         n_checks++;
         if (got_q[i].addr !== exp_q[i].addr || got_q[i].data !== exp_q[i].data) begin
            n_fail++;
            $display("FAIL random_write[%0d]: got addr %0d data %h, expected addr %0d data %h", i, got_q[i].addr, got_q[i].data, exp_q[i].addr, exp_q[i].data);
         end
      end
      n_checks++;
      if (done_q != exp_done_q) begin n_fail++; $display("FAIL random_done: got %0d pulses, expected %0d", done_q.size(), exp_done_q.size()); end
   endtask

   initial begin
      RST_N       = 1'b0;
      iCAPTURE_EN = 1'b0;
      iVSYNC      = 1'b0;
      iHSYNC      = 1'b0;
      iDE         = 1'b0;
      iPIXEL      = '0;
      iTHRESHOLD  = 8'h80;
      m_active    = 0;
      m_v         = 0;
      m_err       = 0;
      test_reset();
      test_basic();
      test_short_line();
      test_vactive_limit();
      test_vsync_abort();
      test_capture_stop();
      test_filter();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
